// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline sequencing, forwarding and hazard control for a
//            five-stage RV32I core.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module hazard_ctrl #(
  parameter int FILL_CYCLES = 2,
  parameter int TIMEOUT     = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic [1:0]       ResultSrc_e,
  input  logic             PCSrc_e,
  input  logic             RegWrite_m,
  input  logic [4:0]       rd_m,
  input  logic             RegWrite_w,
  input  logic [4:0]       rd_w,
  input  logic             mem_req_m,
  input  logic             mem_ready,
  output logic [1:0]       ForwardA_e,
  output logic [1:0]       ForwardB_e,
  output logic             pc_en,
  output logic             fd_en,
  output logic             fd_clr,
  output logic             de_en,
  output logic             de_clr,
  output logic             em_en,
  output logic             mw_en,
  output logic             mw_clr,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] S_FILL     = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_MEM_WAIT = 2'd2;
  localparam logic [1:0] S_ERROR    = 2'd3;

  localparam int FILL_W = $clog2(FILL_CYCLES + 1) + 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1) + 1;

  // A zero-length fill or timeout degenerates to a single cycle.
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'((FILL_CYCLES > 0) ? FILL_CYCLES - 1 : 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [1:0]        state_q, state_d;
  logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic lwstall;
  logic freeze;

  // M-stage result is newer than W-stage, so it wins when both match.
  always_comb begin
    ForwardA_e = 2'b00;
    if (RegWrite_m && (rd_m != 5'd0) && (rd_m == rs1_e))
      ForwardA_e = 2'b10;
    else if (RegWrite_w && (rd_w != 5'd0) && (rd_w == rs1_e))
      ForwardA_e = 2'b01;
  end

  always_comb begin
    ForwardB_e = 2'b00;
    if (RegWrite_m && (rd_m != 5'd0) && (rd_m == rs2_e))
      ForwardB_e = 2'b10;
    else if (RegWrite_w && (rd_w != 5'd0) && (rd_w == rs2_e))
      ForwardB_e = 2'b01;
  end

  assign lwstall = (ResultSrc_e == 2'b01) && (rd_e != 5'd0) &&
                   ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign freeze  = mem_req_m && !mem_ready;

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    pc_en       = 1'b0;
    fd_en       = 1'b0;
    fd_clr      = 1'b0;
    de_en       = 1'b0;
    de_clr      = 1'b0;
    em_en       = 1'b0;
    mw_en       = 1'b0;
    mw_clr      = 1'b0;

    case (state_q)
      S_FILL: begin
        fd_clr     = 1'b1;
        de_en      = 1'b1;
        de_clr     = 1'b1;
        em_en      = 1'b1;
        mw_en      = 1'b1;
        fill_cnt_d = fill_cnt_q + FILL_W'(1);
        if (fill_cnt_q >= FILL_LAST)
          state_d = S_RUN;
      end

      S_RUN, S_MEM_WAIT: begin
        pc_en = 1'b1;
        fd_en = 1'b1;
        de_en = 1'b1;
        em_en = 1'b1;
        mw_en = 1'b1;
        // A freeze holds E, so branch and load-use are re-judged once it lifts.
        if (freeze) begin
          pc_en  = 1'b0;
          fd_en  = 1'b0;
          de_en  = 1'b0;
          em_en  = 1'b0;
          mw_clr = 1'b1;
        end else if (PCSrc_e) begin
          fd_clr = 1'b1;
          de_clr = 1'b1;
        end else if (lwstall) begin
          pc_en  = 1'b0;
          fd_en  = 1'b0;
          de_clr = 1'b1;
        end

        if ((freeze || (lwstall && !PCSrc_e)) && (stall_cnt_q != CNT_MAX))
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if ((state_q == S_RUN) && !freeze && PCSrc_e && (flush_cnt_q != CNT_MAX))
          flush_cnt_d = flush_cnt_q + CNT_W'(1);

        if (state_q == S_RUN) begin
          if (freeze) begin
            state_d    = S_MEM_WAIT;
            wait_cnt_d = '0;
          end
        end else begin
          if (!freeze)
            state_d = S_RUN;
          else if (wait_cnt_q >= WAIT_LAST)
            state_d = S_ERROR;
          else
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      S_ERROR: begin
        state_d = S_ERROR;
      end

      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FILL;
      fill_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_err   = (state_q == S_ERROR);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed self-checking bench for hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [4:0]       rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0]       ResultSrc_e;
  logic             PCSrc_e, RegWrite_m, RegWrite_w, mem_req_m, mem_ready;
  logic [1:0]       ForwardA_e, ForwardB_e;
  logic             pc_en, fd_en, fd_clr, de_en, de_clr, em_en, mw_en, mw_clr, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  hazard_ctrl #(
    .FILL_CYCLES (2),
    .TIMEOUT     (16),
    .CNT_W       (CNT_W)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rs1_d       (rs1_d),
    .rs2_d       (rs2_d),
    .rs1_e       (rs1_e),
    .rs2_e       (rs2_e),
    .rd_e        (rd_e),
    .ResultSrc_e (ResultSrc_e),
    .PCSrc_e     (PCSrc_e),
    .RegWrite_m  (RegWrite_m),
    .rd_m        (rd_m),
    .RegWrite_w  (RegWrite_w),
    .rd_w        (rd_w),
    .mem_req_m   (mem_req_m),
    .mem_ready   (mem_ready),
    .ForwardA_e  (ForwardA_e),
    .ForwardB_e  (ForwardB_e),
    .pc_en       (pc_en),
    .fd_en       (fd_en),
    .fd_clr      (fd_clr),
    .de_en       (de_en),
    .de_clr      (de_clr),
    .em_en       (em_en),
    .mw_en       (mw_en),
    .mw_clr      (mw_clr),
    .mem_err     (mem_err),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1_d = 5'd0; rs2_d = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0; rd_e = 5'd0;
    rd_m = 5'd0; rd_w = 5'd0; ResultSrc_e = 2'b00; PCSrc_e = 1'b0;
    RegWrite_m = 1'b0; RegWrite_w = 1'b0; mem_req_m = 1'b0; mem_ready = 1'b1;
  endtask

  // Reset, release just after an edge, then ride out the two fill cycles.
  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Fill window: two cycles with PC held and F/D, D/E cleared.
    for (int i = 0; i < 2; i++) begin
      #1;
      check("fill_pc_en", pc_en, 0);
      check("fill_fd_clr", fd_clr, 1);
      check("fill_de_clr", de_clr, 1);
      step();
    end
    #1;
    check("run_pc_en", pc_en, 1);
    check("run_fd_clr", fd_clr, 0);
    check("run_stall0", stall_cnt, 0);
    check("run_flush0", flush_cnt, 0);

    // Forwarding priority
    RegWrite_m = 1'b1; rd_m = 5'd5; RegWrite_w = 1'b1; rd_w = 5'd5;
    rs1_e = 5'd5; rs2_e = 5'd5;
    #1;
    check("fwdA_m", ForwardA_e, 2'b10);
    check("fwdB_m", ForwardB_e, 2'b10);
    rd_m = 5'd0;
    #1;
    check("fwdA_w", ForwardA_e, 2'b01);
    rd_w = 5'd0;
    #1;
    check("fwdA_none", ForwardA_e, 2'b00);
    rd_m = 5'd5;
    #1;
    check("fwdA_m_only", ForwardA_e, 2'b10);
    rs2_e = 5'd7;
    #1;
    check("fwdB_nomatch", ForwardB_e, 2'b00);
    idle();

    // Load-use stall
    ResultSrc_e = 2'b01; rd_e = 5'd6; rs2_d = 5'd6;
    #1;
    check("lw_pc_en", pc_en, 0);
    check("lw_fd_en", fd_en, 0);
    check("lw_de_clr", de_clr, 1);
    check("lw_fd_clr", fd_clr, 0);
    step();
    idle();
    #1;
    check("lw_stall_cnt", stall_cnt, 1);

    // Branch taken together with load-use
    ResultSrc_e = 2'b01; rd_e = 5'd6; rs2_d = 5'd6; PCSrc_e = 1'b1;
    #1;
    check("br_fd_clr", fd_clr, 1);
    check("br_de_clr", de_clr, 1);
    check("br_pc_en", pc_en, 1);
    step();
    idle();
    #1;
    check("br_flush_cnt", flush_cnt, 1);
    check("br_stall_cnt", stall_cnt, 1);

    // Three not-ready cycles
    do_reset();
    mem_req_m = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("frz_pc_en", pc_en, 0);
      check("frz_mw_clr", mw_clr, 1);
      check("frz_em_en", em_en, 0);
      step();
    end
    mem_ready = 1'b1;
    #1;
    check("unfrz_pc_en", pc_en, 1);
    check("unfrz_mw_clr", mw_clr, 0);
    step();
    idle();
    #1;
    check("frz_stall_cnt", stall_cnt, 3);
    check("back_run_pc_en", pc_en, 1);

    // Zero-wait access
    mem_req_m = 1'b1; mem_ready = 1'b1;
    #1;
    check("zw_pc_en", pc_en, 1);
    check("zw_mw_clr", mw_clr, 0);
    step();
    idle();
    #1;
    check("zw_stall_cnt", stall_cnt, 3);

    // Timeout: 1 RUN cycle + 16 not-ready MEM_WAIT cycles
    mem_req_m = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      #1;
      if (i == 0 || i == 16) check("to_no_err", mem_err, 0);
      step();
    end
    #1;
    check("to_err", mem_err, 1);
    check("to_pc_en", pc_en, 0);
    check("to_mw_en", mw_en, 0);
    check("to_mw_clr", mw_clr, 0);
    mem_ready = 1'b1;
    step();
    check("to_err_sticky", mem_err, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_err", mem_err, 0);
    check("arst_fd_clr", fd_clr, 1);
    check("arst_pc_en", pc_en, 0);

    // Counter saturation
    do_reset();
    ResultSrc_e = 2'b01; rd_e = 5'd9; rs1_d = 5'd9;
    for (int i = 0; i < 20; i++) step();
    idle();
    #1;
    check("sat_stall_cnt", stall_cnt, 15);
    check("sat_flush_cnt", flush_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage RV32I core. It generates the enable and clear controls for the PC register and the F/D, D/E, E/M and M/W pipeline registers. It also produces the E-stage forwarding selects, detects load-use and control hazards, and freezes the pipeline while data memory is not ready. It sits beside the datapath: it reads register addresses and control bits from each stage and drives every pipeline register's enable/clear inputs.

## Interface
Parameters:
- FILL_CYCLES, 2, cycles after reset release during which F/D and D/E are held cleared and the PC is held.
- TIMEOUT, 16, maximum consecutive not-ready cycles in MEM_WAIT before an error is raised.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rs1_d, rs2_d  in  5  D-stage source registers.
- rs1_e, rs2_e, rd_e  in  5  E-stage source and destination registers.
- ResultSrc_e  in  2  E-stage result select; 2'b01 means load.
- PCSrc_e  in  1  branch taken or jump in E.
- RegWrite_m  in  1  M-stage register write.
- rd_m  in  5  M-stage destination register.
- RegWrite_w  in  1  W-stage register write.
- rd_w  in  5  W-stage destination register.
- mem_req_m  in  1  M-stage load or store is active.
- mem_ready  in  1  data memory completes the access this cycle.
- ForwardA_e, ForwardB_e  out  2  forwarding selects: 00 register file, 01 W result, 10 M ALU result.
- pc_en, fd_en, fd_clr, de_en, de_clr, em_en, mw_en, mw_clr  out  1  pipeline register controls; clear has priority over enable inside each register.
- mem_err  out  1  memory timeout, sticky until reset.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

## Operation
- States: FILL, RUN, MEM_WAIT, ERROR. Reset enters FILL with the fill counter at 0, the wait counter at 0, both event counters at 0, and mem_err at 0.
- FILL: outputs pc_en=0, fd_en=0, fd_clr=1, de_en=1, de_clr=1, em_en=1, mw_en=1, mw_clr=0.
  - The fill counter increments each cycle.
  - Go to RUN after FILL_CYCLES cycles in FILL.
  - Counters do not count.
- Forwarding is combinational and independent of state. ForwardA_e is computed from rs1_e; ForwardB_e uses the same rules with rs2_e:
  - 10 when RegWrite_m, rd_m≠0 and rd_m==rs1_e.
  - Otherwise 01 when RegWrite_w, rd_w≠0 and rd_w==rs1_e.
  - Otherwise 00. M has priority over W.
- lwstall = (ResultSrc_e==2'b01) and rd_e≠0 and (rd_e==rs1_d or rd_e==rs2_d).
- freeze = mem_req_m and not mem_ready.
- RUN/MEM_WAIT defaults: all enables 1, all clears 0.
- Priority order, highest first, in RUN and MEM_WAIT:
  1. freeze: pc_en=fd_en=de_en=em_en=0, mw_en=1, mw_clr=1 (bubble into W); fd_clr=de_clr=0. Pending lwstall and PCSrc_e are ignored this cycle and are re-evaluated when the freeze lifts, because the E inputs are held.
  2. PCSrc_e: fd_clr=1, de_clr=1, pc_en=1. This also covers the case where lwstall is asserted at the same time.
  3. lwstall: pc_en=0, fd_en=0, de_clr=1.
- Transitions:
  - RUN→MEM_WAIT when freeze.
  - MEM_WAIT→RUN on the cycle mem_ready=1; that cycle is unfrozen.
  - MEM_WAIT→ERROR when the wait counter reaches TIMEOUT−1 and mem_ready=0.
  - The wait counter clears on entry to MEM_WAIT and increments each not-ready cycle in MEM_WAIT.
- ERROR: all enables 0, all clears 0, mem_err=1. ERROR is left only by reset.
- stall_cnt increments in any RUN/MEM_WAIT cycle with freeze or (lwstall and not PCSrc_e). flush_cnt increments in any unfrozen RUN cycle with PCSrc_e. Both counters saturate at all-ones.

## Timing
- Forwarding selects and all stage controls are combinational from current inputs and state; the registers act on the same rising edge.
- Load-use costs exactly one bubble: the dependent instruction stays in D for one cycle, then forwarding uses path 01.
- Taken branch/jump costs two bubbles: F/D and D/E are cleared on the same edge the PC loads the target.
- A zero-wait access (mem_req_m and mem_ready in the same cycle) causes no stall and no state change.
- An access with k not-ready cycles (k < TIMEOUT) freezes for exactly k cycles.
- Async reset mid-MEM_WAIT or mid-ERROR returns the block to FILL immediately, with all outputs at their FILL values.

## Test plan
- Reset release with FILL_CYCLES=2 -> fd_clr=de_clr=1 and pc_en=0 for exactly 2 cycles, then pc_en=1; counters read 0.
- Back-to-back hazard: M writes x5 while W writes x5, rs1_e=5 -> ForwardA_e=10. Then with rd_m=0 and rd_w=5 -> ForwardA_e=01. With rd_w=0 in both cases -> 00.
- Load x6 in E with rs2_d=6 -> one cycle of pc_en=0, fd_en=0, de_clr=1; stall_cnt=1. Same stimulus with PCSrc_e=1 -> fd_clr=de_clr=1, pc_en=1, flush_cnt=1, stall_cnt unchanged.
- mem_req_m with mem_ready low for 3 cycles -> exactly 3 frozen cycles with mw_clr=1; stall_cnt=3; back in RUN after mem_ready rises.
- mem_ready held low with TIMEOUT=16 -> mem_err=1 after 16 not-ready cycles in MEM_WAIT and stays set; asserting rst_n=0 mid-error clears it asynchronously.
- Counter saturation with CNT_W=4 -> 20 lwstall cycles leave stall_cnt=15.
